shift_unit: RTL



---
 rtl/shift_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// shift_unit: iterative 32-bit shifter (SLL/SRL/SRA/pass-through) with a start/done handshake.
// One shift step per cycle. Define SHIFT_UNIT_STEP4_EN to step by 4 while >= 4 positions remain;
// the results are the same in both builds and only the latency differs.

module shift_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] in_data_i,
  input  logic [31:0] shamt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSrl  = 2'b01;
  localparam logic [1:0] OpSra  = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  state_e      state_q;
  logic [31:0] work_q;
  logic [1:0]  op_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic [5:0]  n_eff;
  logic [2:0]  step_amt;
  logic [5:0]  cnt_next;
  logic [31:0] work_step;

  // Effective count at acceptance: any high shamt bit saturates to 32; pass-through needs no steps
  always_comb begin
    n_eff = (|shamt_i[31:5]) ? 6'd32 : {1'b0, shamt_i[4:0]};
    if (op_i == OpPass) begin
      n_eff = 6'd0;
    end
  end

  // One shift step on the working register, plus the count left after that step
  always_comb begin
`ifdef SHIFT_UNIT_STEP4_EN
    step_amt = (cnt_q >= 6'd4) ? 3'd4 : 3'd1;
`else
    step_amt = 3'd1;
`endif
    cnt_next = cnt_q - {3'b000, step_amt};
    work_step = work_q;
    unique case (op_q)
      OpSll:   work_step = work_q << step_amt;
      OpSrl:   work_step = work_q >> step_amt;
      OpSra:   work_step = $signed(work_q) >>> step_amt;
      default: work_step = work_q;
    endcase
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      work_q   <= 32'h0;
      op_q     <= 2'b00;
      cnt_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            work_q <= in_data_i;
            op_q   <= op_i;
            cnt_q  <= n_eff;
            busy_q <= 1'b1;
            if (n_eff == 6'd0) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= in_data_i;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          work_q <= work_step;
          cnt_q  <= cnt_next;
          if (cnt_next == 6'd0) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= work_step;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
